// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx
//
// Drains a standard (non-show-ahead) 256x8 FIFO one byte at a time and sends
// each byte as an 8N1 UART frame, LSB first. New frames start only while
// tx_en is high and the FIFO is not empty. Both inputs are looked at only
// between frames, so a frame that has started always completes.
//
// Parameters:
//   CLK_FREQ   system clock frequency in Hz
//   UART_BPS   baud rate; one bit lasts CLK_FREQ/UART_BPS clocks (2..65535)
//
// Ports:
//   sys_clk     system clock, all logic on the rising edge
//   sys_rst     asynchronous active-high reset
//   tx_en       permits new frames to start
//   fifo_dout   FIFO read data, valid the cycle after fifo_rd_en is sampled
//   fifo_empty  FIFO empty flag
//   fifo_rd_en  registered one-cycle read strobe, one per frame
//   uart_txd    serial line, idles high
//   tx_busy     high whenever the state machine is not idle
//   tx_done     one-cycle pulse in the first idle cycle after a stop bit

module uart_fifo_tx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 115200
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       tx_en,
    input  logic [7:0] fifo_dout,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    output logic       uart_txd,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int          BPS_CNT   = CLK_FREQ / UART_BPS;
    localparam logic [15:0] BAUD_LAST = 16'(BPS_CNT - 1);

    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_REQ   = 6'b000010,
        S_LATCH = 6'b000100,
        S_START = 6'b001000,
        S_DATA  = 6'b010000,
        S_STOP  = 6'b100000
    } state_t;

    state_t      state;
    state_t      state_d;
    logic [15:0] baud_cnt;
    logic [15:0] baud_cnt_d;
    logic [2:0]  bit_cnt;
    logic [2:0]  bit_cnt_d;
    logic [7:0]  tx_data;
    logic [7:0]  tx_data_d;
    logic        rd_en_d;
    logic        txd_d;
    logic        done_d;
    logic        baud_last;
    logic [2:0]  bit_next;

    // End of the current bit period, and the index of the next data bit to
    // put on the line when that period ends.
    assign baud_last = (baud_cnt == BAUD_LAST);
    assign bit_next  = bit_cnt + 3'd1;

    // Busy is simply "not idle"; because the state is registered this rises
    // on the edge entering REQ and falls on the edge entering IDLE.
    assign tx_busy = (state != S_IDLE);

    // State and datapath registers. Every output except tx_busy is registered
    // here so the FIFO and the serial line see glitch-free signals. Reset drops
    // any byte that was in flight and returns the line to idle-high at once.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= S_IDLE;
            baud_cnt   <= 16'd0;
            bit_cnt    <= 3'd0;
            tx_data    <= 8'd0;
            fifo_rd_en <= 1'b0;
            uart_txd   <= 1'b1;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_d;
            baud_cnt   <= baud_cnt_d;
            bit_cnt    <= bit_cnt_d;
            tx_data    <= tx_data_d;
            fifo_rd_en <= rd_en_d;
            uart_txd   <= txd_d;
            tx_done    <= done_d;
        end
    end

    // Next-state and next-output logic. The read strobe is raised when leaving
    // IDLE and dropped in REQ, so the FIFO samples it at the REQ->LATCH edge
    // and presents the byte during LATCH, where it is captured. From then on
    // only tx_data feeds the line, so later fifo_dout changes are harmless.
    // The baud counter runs 0..BPS_CNT-1 in START, DATA and STOP and clears on
    // each terminal count, giving exactly BPS_CNT clocks per bit.
    always_comb begin
        state_d    = state;
        baud_cnt_d = baud_cnt;
        bit_cnt_d  = bit_cnt;
        tx_data_d  = tx_data;
        rd_en_d    = 1'b0;
        txd_d      = uart_txd;
        done_d     = 1'b0;

        case (state)
            S_IDLE: begin
                txd_d      = 1'b1;
                baud_cnt_d = 16'd0;
                if (tx_en && !fifo_empty) begin
                    rd_en_d = 1'b1;
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                state_d = S_LATCH;
            end

            S_LATCH: begin
                tx_data_d  = fifo_dout;
                txd_d      = 1'b0;
                baud_cnt_d = 16'd0;
                state_d    = S_START;
            end

            S_START: begin
                if (baud_last) begin
                    baud_cnt_d = 16'd0;
                    bit_cnt_d  = 3'd0;
                    txd_d      = tx_data[0];
                    state_d    = S_DATA;
                end else begin
                    baud_cnt_d = baud_cnt + 16'd1;
                end
            end

            S_DATA: begin
                if (baud_last) begin
                    baud_cnt_d = 16'd0;
                    if (bit_cnt == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_cnt_d = bit_next;
                        txd_d     = tx_data[bit_next];
                    end
                end else begin
                    baud_cnt_d = baud_cnt + 16'd1;
                end
            end

            S_STOP: begin
                if (baud_last) begin
                    baud_cnt_d = 16'd0;
                    done_d     = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    baud_cnt_d = baud_cnt + 16'd1;
                end
            end

            default: begin
                state_d    = S_IDLE;
                txd_d      = 1'b1;
                baud_cnt_d = 16'd0;
                bit_cnt_d  = 3'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// tb_uart_fifo_tx
//
// Bench for uart_fifo_tx at BPS_CNT = 10. A byte-array FIFO model feeds the
// design; a line decoder samples each frame mid-bit and compares it with a
// frame built from the bytes pushed into the FIFO, plus fixed frames from a
// small vector table.

module tb_uart_fifo_tx;

    localparam int BPS = 10;

    typedef struct {
        logic [7:0] data;
        logic [9:0] expFrame;
    } vec_t;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       tx_en = 1'b0;
    logic [7:0] fifo_dout = 8'd0;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic       uart_txd;
    logic       tx_busy;
    logic       tx_done;

    int vectors = 0;
    int miscompares = 0;

    int         cyc = 0;
    logic [7:0] mem [256];
    int         wrPtr = 0;
    int         rdPtr = 0;
    int         underflows = 0;
    bit         scramble = 1'b0;

    int rdCount = 0;
    int doneCount = 0;
    int overlapCount = 0;
    int lastRdCyc = 0;

    logic [7:0] expQ [$];
    vec_t       vecs [5];

    uart_fifo_tx #(
        .CLK_FREQ(1_000_000),
        .UART_BPS(100_000)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .tx_en     (tx_en),
        .fifo_dout (fifo_dout),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .uart_txd  (uart_txd),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    // 100 MHz-style free-running clock (period 10 time units).
    always #5 sys_clk = ~sys_clk;

    // Cycle counter used to timestamp read strobes and line edges.
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Standard-mode FIFO model: a read strobe sampled at an edge presents the
    // next byte after that edge. Reading while empty is counted as underflow.
    // In scramble mode the read port shows garbage whenever no read happens.
    assign fifo_empty = (wrPtr == rdPtr);

    always @(posedge sys_clk) begin
        if (fifo_rd_en) begin
            if (wrPtr == rdPtr) begin
                underflows <= underflows + 1;
            end else begin
                fifo_dout <= mem[rdPtr % 256];
                rdPtr     <= rdPtr + 1;
            end
        end else if (scramble) begin
            fifo_dout <= 8'($urandom);
        end
    end

    // Output monitor on the falling edge: counts read strobes and done
    // pulses, and notes any cycle where both are high together.
    always @(negedge sys_clk) begin
        if (fifo_rd_en) begin
            rdCount   = rdCount + 1;
            lastRdCyc = cyc;
        end
        if (tx_done) doneCount = doneCount + 1;
        if (fifo_rd_en && tx_done) overlapCount = overlapCount + 1;
    end

    // Safety net so a stuck design can never hang the run.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference frame: start bit 0, eight data bits LSB first, stop bit 1,
    // indexed in transmission order.
    function automatic logic [9:0] modelFrame(input logic [7:0] b);
        logic [9:0] f;
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      f[k] = 1'b0;
            else if (k == 9) f[k] = 1'b1;
            else             f[k] = 1'(int'(b) >> (k - 1));
        end
        return f;
    endfunction

    // One comparison: count it, and report it if it differs.
    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors = vectors + 1;
        if (actual !== expected) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Push one byte into the FIFO model and the scoreboard.
    task automatic applyStimulus(input logic [7:0] b);
        mem[wrPtr % 256] = b;
        wrPtr = wrPtr + 1;
        expQ.push_back(b);
    endtask

    // Wait (bounded) for the line to fall; reports the cycle it was seen.
    task automatic waitFall(input string tag, output bit ok, output int fellAt);
        int n;
        n = 0;
        while (uart_txd === 1'b1 && n < 400) begin
            @(negedge sys_clk);
            n++;
        end
        ok = (uart_txd === 1'b0);
        fellAt = cyc;
        if (!ok) checkOutput({tag, "_start_timeout"}, 0, 1);
    endtask

    // Decode one frame mid-bit, check read-strobe latency, tx_done timing and
    // the decoded bits against the scoreboard. Optionally drops tx_en while
    // frame bit dropBit is on the line. Returns at the first idle cycle.
    task automatic receiveFrame(input string tag, input int dropBit,
                                output logic [9:0] bits, output int fellAt);
        bit         ok;
        logic       d99;
        logic       d100;
        logic [7:0] expByte;
        bits = '1;
        waitFall(tag, ok, fellAt);
        if (!ok) return;
        checkOutput({tag, "_rd_to_fall"}, fellAt - lastRdCyc, 2);
        repeat (5) @(negedge sys_clk);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) repeat (BPS) @(negedge sys_clk);
            if (k == dropBit) tx_en = 1'b0;
            bits[k] = uart_txd;
        end
        repeat (4) @(negedge sys_clk);
        d99 = tx_done;
        @(negedge sys_clk);
        d100 = tx_done;
        checkOutput({tag, "_done_timing"}, int'({d99, d100}), 1);
        if (expQ.size() == 0) begin
            checkOutput({tag, "_unexpected_frame"}, int'(bits), 0);
        end else begin
            expByte = expQ.pop_front();
            checkOutput({tag, "_frame"}, int'(bits), int'(modelFrame(expByte)));
        end
    endtask

    // Watch the outputs for a while and count line-low and busy cycles.
    task automatic watchIdle(input int cycles, output int lowSeen, output int busySeen);
        lowSeen = 0;
        busySeen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge sys_clk);
            if (uart_txd !== 1'b1) lowSeen++;
            if (tx_busy !== 1'b0) busySeen++;
        end
    endtask

    initial begin
        logic [9:0] bits;
        int         f0;
        int         f1;
        int         f2;
        int         r0;
        int         d0;
        int         lowSeen;
        int         busySeen;
        int         n;
        bit         ok;
        logic [7:0] lost;

        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h3C, 10'b1001111000};
        vecs[4] = '{8'h81, 10'b1100000010};

        // Reset state.
        repeat (3) @(negedge sys_clk);
        checkOutput("reset_txd", int'(uart_txd), 1);
        checkOutput("reset_rd_en", int'(fifo_rd_en), 0);
        checkOutput("reset_busy", int'(tx_busy), 0);
        checkOutput("reset_done", int'(tx_done), 0);
        sys_rst = 1'b0;

        // Enabled but empty: nothing may happen.
        tx_en = 1'b1;
        r0 = rdCount;
        watchIdle(200, lowSeen, busySeen);
        checkOutput("empty_rd_pulses", rdCount - r0, 0);
        checkOutput("empty_txd_low", lowSeen, 0);
        checkOutput("empty_busy", busySeen, 0);

        // Table vectors, one isolated frame each.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].data);
            d0 = doneCount;
            r0 = rdCount;
            receiveFrame($sformatf("vec%0d", i), -1, bits, f0);
            checkOutput($sformatf("vec%0d_table", i), int'(bits), int'(vecs[i].expFrame));
            repeat (3) @(negedge sys_clk);
            checkOutput($sformatf("vec%0d_done_count", i), doneCount - d0, 1);
            checkOutput($sformatf("vec%0d_rd_count", i), rdCount - r0, 1);
            checkOutput($sformatf("vec%0d_busy_after", i), int'(tx_busy), 0);
        end

        // Back-to-back frames from a three-byte FIFO.
        r0 = rdCount;
        applyStimulus(vecs[1].data);
        applyStimulus(vecs[2].data);
        applyStimulus(vecs[3].data);
        receiveFrame("b2b0", -1, bits, f0);
        checkOutput("b2b0_table", int'(bits), int'(vecs[1].expFrame));
        receiveFrame("b2b1", -1, bits, f1);
        checkOutput("b2b1_table", int'(bits), int'(vecs[2].expFrame));
        receiveFrame("b2b2", -1, bits, f2);
        checkOutput("b2b2_table", int'(bits), int'(vecs[3].expFrame));
        checkOutput("b2b_gap1", f1 - f0 - 9 * BPS, BPS + 3);
        checkOutput("b2b_gap2", f2 - f1 - 9 * BPS, BPS + 3);
        repeat (5) @(negedge sys_clk);
        checkOutput("b2b_rd_count", rdCount - r0, 3);
        checkOutput("b2b_fifo_empty", int'(fifo_empty), 1);
        checkOutput("b2b_underflow", underflows, 0);

        // tx_en dropped during data bit 4; the frame completes, then stalls.
        applyStimulus(8'($urandom));
        applyStimulus(8'($urandom));
        applyStimulus(8'($urandom));
        receiveFrame("drop0", 5, bits, f0);
        r0 = rdCount;
        watchIdle(50, lowSeen, busySeen);
        checkOutput("drop_rd_pulses", rdCount - r0, 0);
        checkOutput("drop_txd_low", lowSeen, 0);
        checkOutput("drop_busy", busySeen, 0);
        tx_en = 1'b1;
        receiveFrame("drop1", -1, bits, f0);
        receiveFrame("drop2", -1, bits, f0);

        // Asynchronous reset in the middle of the data bits.
        applyStimulus(8'h00);
        applyStimulus(8'hC3);
        waitFall("rst", ok, f0);
        if (ok) begin
            repeat (35) @(negedge sys_clk);
            checkOutput("pre_reset_txd", int'(uart_txd), 0);
            #1 sys_rst = 1'b1;
            #1;
            checkOutput("async_reset_txd", int'(uart_txd), 1);
            checkOutput("async_reset_busy", int'(tx_busy), 0);
            repeat (3) @(negedge sys_clk);
            sys_rst = 1'b0;
        end
        lost = expQ.pop_front();
        receiveFrame("post_reset", -1, bits, f0);
        checkOutput("post_reset_table", int'(bits), int'(modelFrame(8'hC3)));

        // Read data changing every cycle after capture.
        scramble = 1'b1;
        applyStimulus(8'h5A);
        receiveFrame("scramble", -1, bits, f0);
        checkOutput("scramble_table", int'(bits), int'(10'b1010110100));
        scramble = 1'b0;

        // Random bursts against the scoreboard.
        for (int b = 0; b < 6; b++) begin
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) applyStimulus(8'($urandom));
            for (int j = 0; j < n; j++) receiveFrame($sformatf("rnd%0d_%0d", b, j), -1, bits, f0);
            repeat ($urandom_range(0, 20)) @(negedge sys_clk);
        end

        repeat (5) @(negedge sys_clk);
        checkOutput("final_underflow", underflows, 0);
        checkOutput("final_rd_done_overlap", overlapCount, 0);
        checkOutput("final_fifo_empty", int'(fifo_empty), 1);
        checkOutput("final_scoreboard_left", expQ.size(), 0);
        if (lost !== 8'h00) $display("[TB] note: lost byte 0x%0h", lost);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
